// File: rtl/ddr3_avl_pkg.sv
// ============================================================================
// Module   : ddr3_avl_pkg
// Brief    : Shared types and defaults for the DDR3 Avalon-MM two-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ddr3_avl_pkg;

    localparam int DEF_ADDR_W = 26;
    localparam int DEF_DATA_W = 128;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_WR_LOCK = 1'b1
    } arb_state_t;

    // port: 0 = A, 1 = B; size is the normalised burst length (never 0)
    typedef struct packed {
        logic       port;
        logic [2:0] size;
    } rd_tag_t;

    function automatic logic [2:0] norm_size(input logic [2:0] size);
        return (size == 3'd0) ? 3'd1 : size;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ddr3_rd_tag_fifo.sv
// ============================================================================
// Module   : ddr3_rd_tag_fifo
// Brief    : Synchronous FIFO holding outstanding read tags in issue order.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr3_rd_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = mem[r_rd_ptr];
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/ddr3_avl_arbiter.sv
// ============================================================================
// Module   : ddr3_avl_arbiter
// Brief    : Two-master arbiter for one DDR3 Avalon-MM port with atomic write
//            bursts and in-order read-return routing via a tag FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr3_avl_arbiter
    import ddr3_avl_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int TAG_DEPTH = 8,
    parameter int PRIO_A    = 0
) (
    input  logic                        ddr3_clk,
    input  logic                        ddr3_reset_n,
    input  logic                        a_read_req,
    input  logic                        a_burstbegin,
    input  logic [2:0]                  a_size,
    input  logic [ADDR_W-1:0]           a_addr,
    output logic                        a_ready,
    output logic [DATA_W-1:0]           a_rdata,
    output logic                        a_rdata_valid,
    input  logic                        b_read_req,
    input  logic                        b_write_req,
    input  logic                        b_burstbegin,
    input  logic [2:0]                  b_size,
    input  logic [ADDR_W-1:0]           b_addr,
    input  logic [DATA_W-1:0]           b_wdata,
    input  logic [DATA_W/8-1:0]         b_be,
    output logic                        b_ready,
    output logic [DATA_W-1:0]           b_rdata,
    output logic                        b_rdata_valid,
    input  logic                        ddr3_avl_ready,
    output logic                        ddr3_avl_burstbegin,
    output logic                        ddr3_avl_read_req,
    output logic                        ddr3_avl_write_req,
    output logic [2:0]                  ddr3_avl_size,
    output logic [ADDR_W-1:0]           ddr3_avl_addr,
    output logic [DATA_W-1:0]           ddr3_avl_wdata,
    output logic [DATA_W/8-1:0]         ddr3_avl_be,
    input  logic                        ddr3_avl_read_data_valid,
    input  logic [DATA_W-1:0]           ddr3_avl_read_data,
    output logic [$clog2(TAG_DEPTH):0]  rd_outstanding,
    output logic                        err_size,
    output logic                        err_orphan
);

    arb_state_t r_state;
    logic       r_rr_b;
    logic       r_hold;
    logic       r_hold_b;
    logic [2:0] r_remaining;
    logic [2:0] r_beat;
    logic       r_err_size;
    logic       r_err_orphan;

    logic       w_full;
    logic       w_empty;
    rd_tag_t    w_head;
    logic       w_a_el;
    logic       w_b_wr;
    logic       w_b_el;
    logic       w_gnt_a;
    logic       w_gnt_b;
    logic       w_acc;
    logic       w_push;
    logic       w_rdv_ok;
    logic       w_last;

    assign w_a_el = a_read_req & ~w_full;
    assign w_b_wr = b_write_req & b_burstbegin;
    assign w_b_el = w_b_wr | (b_read_req & ~w_full);

    // A stalled command keeps its grant until accepted so the bus never changes mid-command
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (!ddr3_reset_n) begin
            w_gnt_a = 1'b0;
        end else if (r_state == ST_WR_LOCK) begin
            w_gnt_b = b_write_req;
        end else if (r_hold) begin
            w_gnt_a = w_a_el & ~r_hold_b;
            w_gnt_b = w_b_el & r_hold_b;
        end else if (w_a_el && w_b_el) begin
            if (PRIO_A != 0 || !r_rr_b) w_gnt_a = 1'b1;
            else                        w_gnt_b = 1'b1;
        end else begin
            w_gnt_a = w_a_el;
            w_gnt_b = w_b_el;
        end
    end

    always_comb begin
        ddr3_avl_burstbegin = 1'b0;
        ddr3_avl_read_req   = 1'b0;
        ddr3_avl_write_req  = 1'b0;
        ddr3_avl_size       = 3'd0;
        ddr3_avl_addr       = '0;
        ddr3_avl_wdata      = '0;
        ddr3_avl_be         = '0;
        if (w_gnt_a) begin
            ddr3_avl_burstbegin = a_burstbegin;
            ddr3_avl_read_req   = 1'b1;
            ddr3_avl_size       = norm_size(a_size);
            ddr3_avl_addr       = a_addr;
        end else if (w_gnt_b) begin
            ddr3_avl_burstbegin = (r_state == ST_IDLE) ? b_burstbegin : 1'b0;
            ddr3_avl_write_req  = (r_state == ST_WR_LOCK) | w_b_wr;
            ddr3_avl_read_req   = (r_state == ST_IDLE) & ~w_b_wr;
            ddr3_avl_size       = norm_size(b_size);
            ddr3_avl_addr       = b_addr;
            if (ddr3_avl_write_req) begin
                ddr3_avl_wdata = b_wdata;
                ddr3_avl_be    = b_be;
            end
        end
    end

    assign a_ready = w_gnt_a & ddr3_avl_ready;
    assign b_ready = w_gnt_b & ddr3_avl_ready;
    assign w_acc   = a_ready | b_ready;
    assign w_push  = w_acc & (r_state == ST_IDLE) & ddr3_avl_read_req;

    assign w_rdv_ok      = ddr3_avl_read_data_valid & ~w_empty & ddr3_reset_n;
    assign w_last        = (r_beat == (w_head.size - 3'd1));
    assign a_rdata       = ddr3_avl_read_data;
    assign b_rdata       = ddr3_avl_read_data;
    assign a_rdata_valid = w_rdv_ok & ~w_head.port;
    assign b_rdata_valid = w_rdv_ok & w_head.port;
    assign err_size      = r_err_size;
    assign err_orphan    = r_err_orphan;

    ddr3_rd_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     ($bits(rd_tag_t))
    ) u_tag_fifo (
        .clk   (ddr3_clk),
        .rst_n (ddr3_reset_n),
        .push  (w_push),
        .din   ({w_gnt_b, ddr3_avl_size}),
        .pop   (w_rdv_ok & w_last),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (rd_outstanding)
    );

    always_ff @(posedge ddr3_clk) begin
        if (!ddr3_reset_n) begin
            r_state      <= ST_IDLE;
            r_rr_b       <= 1'b0;
            r_hold       <= 1'b0;
            r_hold_b     <= 1'b0;
            r_remaining  <= 3'd0;
            r_beat       <= 3'd0;
            r_err_size   <= 1'b0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_rdv_ok) begin
                r_beat <= w_last ? 3'd0 : r_beat + 3'd1;
            end
            if (ddr3_avl_read_data_valid && w_empty) begin
                r_err_orphan <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_acc) begin
                        r_hold <= 1'b0;
                        r_rr_b <= w_gnt_a;
                        if (w_gnt_a ? (a_size == 3'd0) : (b_size == 3'd0)) begin
                            r_err_size <= 1'b1;
                        end
                        if (ddr3_avl_write_req && ddr3_avl_size > 3'd1) begin
                            r_state     <= ST_WR_LOCK;
                            r_remaining <= ddr3_avl_size - 3'd1;
                        end
                    end else begin
                        r_hold   <= w_gnt_a | w_gnt_b;
                        r_hold_b <= w_gnt_b;
                    end
                end
                ST_WR_LOCK: begin
                    if (w_acc) begin
                        r_remaining <= r_remaining - 3'd1;
                        if (r_remaining == 3'd1) r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
